// File: rtl/pipe_front_regs.sv
// Front-end pipeline state of the 5-stage RV32I core: PC, IF/ID and ID/EX registers
// with stall/flush/redirect handling, plus saturating stall and flush event counters.
module pipe_front_regs #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             FlushE,
   input  logic             PCSrcE,
   input  logic [XLEN-1:0]  PCTargetE,
   input  logic [31:0]      InstrF,
   input  logic             RegWriteD,
   input  logic             MemWriteD,
   input  logic             JumpD,
   input  logic             BranchD,
   input  logic             ALUSrcD,
   input  logic [1:0]       ResultSrcD,
   input  logic [2:0]       ALUControlD,
   input  logic [XLEN-1:0]  RD1D,
   input  logic [XLEN-1:0]  RD2D,
   input  logic [XLEN-1:0]  ImmExtD,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdD,
   output logic [XLEN-1:0]  PCF,
   output logic [XLEN-1:0]  PCPlus4F,
   output logic [31:0]      InstrD,
   output logic [XLEN-1:0]  PCD,
   output logic [XLEN-1:0]  PCPlus4D,
   output logic             ValidD,
   output logic             RegWriteE,
   output logic             MemWriteE,
   output logic             JumpE,
   output logic             BranchE,
   output logic             ALUSrcE,
   output logic [1:0]       ResultSrcE,
   output logic [2:0]       ALUControlE,
   output logic [XLEN-1:0]  RD1E,
   output logic [XLEN-1:0]  RD2E,
   output logic [XLEN-1:0]  ImmExtE,
   output logic [4:0]       Rs1E,
   output logic [4:0]       Rs2E,
   output logic [4:0]       RdE,
   output logic [XLEN-1:0]  PCE,
   output logic [XLEN-1:0]  PCPlus4E,
   output logic             ValidE,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0]  PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [XLEN-1:0]  XLEN_ZERO = {XLEN{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   // Sequential PC increment, wrapping modulo 2^XLEN.
   assign PCPlus4F = PCF + PC_STEP;

   // PC register: a taken redirect overrides a fetch stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         PCF <= RESET_PC;
      end else if (PCSrcE) begin
         PCF <= PCTargetE;
      end else if (StallF) begin
         PCF <= PCF;
      end else begin
         PCF <= PCPlus4F;
      end
   end

   // IF/ID register: flush inserts a NOP and beats a simultaneous stall.
   always_ff @(posedge clk) begin
      if (reset || FlushD) begin
         InstrD   <= NOP_INSTR;
         PCD      <= XLEN_ZERO;
         PCPlus4D <= XLEN_ZERO;
         ValidD   <= 1'b0;
      end else if (StallD) begin
         InstrD   <= InstrD;
         PCD      <= PCD;
         PCPlus4D <= PCPlus4D;
         ValidD   <= ValidD;
      end else begin
         InstrD   <= InstrF;
         PCD      <= PCF;
         PCPlus4D <= PCPlus4F;
         ValidD   <= 1'b1;
      end
   end

   // ID/EX register: a bubble zeroes register indices too so it never forwards.
   always_ff @(posedge clk) begin
      if (reset || FlushE) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         RD1E        <= XLEN_ZERO;
         RD2E        <= XLEN_ZERO;
         ImmExtE     <= XLEN_ZERO;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
         RdE         <= 5'd0;
         PCE         <= XLEN_ZERO;
         PCPlus4E    <= XLEN_ZERO;
         ValidE      <= 1'b0;
      end else begin
         RegWriteE   <= RegWriteD;
         MemWriteE   <= MemWriteD;
         JumpE       <= JumpD;
         BranchE     <= BranchD;
         ALUSrcE     <= ALUSrcD;
         ResultSrcE  <= ResultSrcD;
         ALUControlE <= ALUControlD;
         RD1E        <= RD1D;
         RD2E        <= RD2D;
         ImmExtE     <= ImmExtD;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= RdD;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
         ValidE      <= ValidD;
      end
   end

   // Saturating event counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         StallCnt <= CNT_ZERO;
         FlushCnt <= CNT_ZERO;
      end else begin
         if (StallF && (StallCnt != CNT_MAX)) begin
            StallCnt <= StallCnt + CNT_ONE;
         end else begin
            StallCnt <= StallCnt;
         end
         if (FlushD && (FlushCnt != CNT_MAX)) begin
            FlushCnt <= FlushCnt + CNT_ONE;
         end else begin
            FlushCnt <= FlushCnt;
         end
      end
   end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs: stimulus pushes hand-computed expectations into a
// queue that a negedge monitor drains and compares against the DUT outputs.
module tb_pipe_front_regs;

   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset, StallF, StallD, FlushD, FlushE, PCSrcE;
   logic [31:0] PCTargetE, InstrF;
   logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
   logic [1:0] ResultSrcD;
   logic [2:0] ALUControlD;
   logic [31:0] RD1D, RD2D, ImmExtD;
   logic [4:0] Rs1D, Rs2D, RdD;
   logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
   logic ValidD, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
   logic [1:0] ResultSrcE;
   logic [2:0] ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0] Rs1E, Rs2E, RdE;
   logic [CW-1:0] StallCnt, FlushCnt;

   pipe_front_regs #(.XLEN(32), .RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
      .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
      .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
      .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .ValidE(ValidE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   typedef enum int {
      S_PCF, S_PC4F, S_INSTRD, S_PCD, S_PC4D, S_VALIDD, S_VALIDE, S_REGWE, S_MEMWE,
      S_JUMPE, S_BRANCHE, S_ALUSRCE, S_RESSRCE, S_ALUCE, S_RD1E, S_RD2E, S_IMME,
      S_RS1E, S_RS2E, S_RDE, S_PCE, S_PC4E, S_STALLC, S_FLUSHC
   } sel_t;

   typedef struct {
      string       name;
      sel_t        sel;
      logic [31:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [31:0] observe(input sel_t s);
      case (s)
         S_PCF:     return PCF;
         S_PC4F:    return PCPlus4F;
         S_INSTRD:  return InstrD;
         S_PCD:     return PCD;
         S_PC4D:    return PCPlus4D;
         S_VALIDD:  return {31'd0, ValidD};
         S_VALIDE:  return {31'd0, ValidE};
         S_REGWE:   return {31'd0, RegWriteE};
         S_MEMWE:   return {31'd0, MemWriteE};
         S_JUMPE:   return {31'd0, JumpE};
         S_BRANCHE: return {31'd0, BranchE};
         S_ALUSRCE: return {31'd0, ALUSrcE};
         S_RESSRCE: return {30'd0, ResultSrcE};
         S_ALUCE:   return {29'd0, ALUControlE};
         S_RD1E:    return RD1E;
         S_RD2E:    return RD2E;
         S_IMME:    return ImmExtE;
         S_RS1E:    return {27'd0, Rs1E};
         S_RS2E:    return {27'd0, Rs2E};
         S_RDE:     return {27'd0, RdE};
         S_PCE:     return PCE;
         S_PC4E:    return PCPlus4E;
         S_STALLC:  return {28'd0, StallCnt};
         S_FLUSHC:  return {28'd0, FlushCnt};
         default:   return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: register outputs settle after posedge; compare every pending expectation.
   initial begin
      exp_t e;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = observe(e.sel);
            checks++;
            if (act !== e.value) begin
               errors++;
               $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.value, $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic ex(input sel_t s, input string n, input logic [31:0] v);
      exp_q.push_back('{name: n, sel: s, value: v});
   endtask

   task automatic ex_ifid(input logic [31:0] instr, input logic [31:0] pcd,
                          input logic [31:0] pc4d, input logic vd);
      ex(S_INSTRD, "InstrD", instr);
      ex(S_PCD, "PCD", pcd);
      ex(S_PC4D, "PCPlus4D", pc4d);
      ex(S_VALIDD, "ValidD", {31'd0, vd});
   endtask

   task automatic ex_bubble();
      ex(S_REGWE, "RegWriteE", 32'd0);   ex(S_MEMWE, "MemWriteE", 32'd0);
      ex(S_JUMPE, "JumpE", 32'd0);       ex(S_BRANCHE, "BranchE", 32'd0);
      ex(S_ALUSRCE, "ALUSrcE", 32'd0);   ex(S_RESSRCE, "ResultSrcE", 32'd0);
      ex(S_ALUCE, "ALUControlE", 32'd0); ex(S_RD1E, "RD1E", 32'd0);
      ex(S_RD2E, "RD2E", 32'd0);         ex(S_IMME, "ImmExtE", 32'd0);
      ex(S_RS1E, "Rs1E", 32'd0);         ex(S_RS2E, "Rs2E", 32'd0);
      ex(S_RDE, "RdE", 32'd0);           ex(S_PCE, "PCE", 32'd0);
      ex(S_PC4E, "PCPlus4E", 32'd0);     ex(S_VALIDE, "ValidE", 32'd0);
   endtask

   // Decode inputs are held at fixed patterns, so a captured E stage must show them.
   task automatic ex_capture(input logic [31:0] pce, input logic [31:0] pc4e, input logic ve);
      ex(S_REGWE, "RegWriteE", 32'd1);   ex(S_MEMWE, "MemWriteE", 32'd1);
      ex(S_JUMPE, "JumpE", 32'd1);       ex(S_BRANCHE, "BranchE", 32'd1);
      ex(S_ALUSRCE, "ALUSrcE", 32'd1);   ex(S_RESSRCE, "ResultSrcE", 32'd2);
      ex(S_ALUCE, "ALUControlE", 32'd5); ex(S_RD1E, "RD1E", 32'h1111_1111);
      ex(S_RD2E, "RD2E", 32'h2222_2222); ex(S_IMME, "ImmExtE", 32'h0000_0ABC);
      ex(S_RS1E, "Rs1E", 32'd5);         ex(S_RS2E, "Rs2E", 32'd6);
      ex(S_RDE, "RdE", 32'd7);           ex(S_PCE, "PCE", pce);
      ex(S_PC4E, "PCPlus4E", pc4e);      ex(S_VALIDE, "ValidE", {31'd0, ve});
   endtask

   task automatic ex_cnt(input logic [31:0] sc, input logic [31:0] fc);
      ex(S_STALLC, "StallCnt", sc);
      ex(S_FLUSHC, "FlushCnt", fc);
   endtask

   // Start a new cycle's stimulus just after the falling edge with all controls idle.
   task automatic clr();
      @(negedge clk);
      #1;
      reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
      PCSrcE = 1'b0; PCTargetE = 32'd0; InstrF = 32'd0;
   endtask

   task automatic tick();
      @(posedge clk);
   endtask

   initial begin
      reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
      PCSrcE = 1'b0; PCTargetE = 32'd0; InstrF = 32'd0;
      RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; BranchD = 1'b1; ALUSrcD = 1'b1;
      ResultSrcD = 2'b10; ALUControlD = 3'b101;
      RD1D = 32'h1111_1111; RD2D = 32'h2222_2222; ImmExtD = 32'h0000_0ABC;
      Rs1D = 5'd5; Rs2D = 5'd6; RdD = 5'd7;

      // Reset state
      clr(); reset = 1'b1; tick();
      ex(S_PCF, "rst_PCF", 32'h0); ex(S_PC4F, "rst_PCPlus4F", 32'h4);
      ex_ifid(32'h0000_0013, 32'h0, 32'h0, 1'b0); ex_bubble(); ex_cnt(32'd0, 32'd0);

      // Free-running fetch, one-cycle IF->ID and two-cycle IF->EX latency
      clr(); InstrF = 32'hC0DE_0000; tick();
      ex(S_PCF, "run1_PCF", 32'h4);
      ex_ifid(32'hC0DE_0000, 32'h0, 32'h4, 1'b1); ex_capture(32'h0, 32'h0, 1'b0);
      clr(); InstrF = 32'hC0DE_0004; tick();
      ex(S_PCF, "run2_PCF", 32'h8);
      ex_ifid(32'hC0DE_0004, 32'h4, 32'h8, 1'b1); ex_capture(32'h0, 32'h4, 1'b1);
      clr(); InstrF = 32'hC0DE_0008; tick();
      ex(S_PCF, "run3_PCF", 32'hC);
      ex_ifid(32'hC0DE_0008, 32'h8, 32'hC, 1'b1); ex_capture(32'h4, 32'h8, 1'b1);
      clr(); InstrF = 32'hAAAA_0003; tick();
      ex(S_PCF, "run4_PCF", 32'h10);
      ex_ifid(32'hAAAA_0003, 32'hC, 32'h10, 1'b1); ex_capture(32'h8, 32'hC, 1'b1);

      // Load-use stall: PC and IF/ID hold, bubble into E
      clr(); StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1; InstrF = 32'hC0DE_0010; tick();
      ex(S_PCF, "lu_PCF", 32'h10); ex(S_PC4F, "lu_PCPlus4F", 32'h14);
      ex_ifid(32'hAAAA_0003, 32'hC, 32'h10, 1'b1); ex_bubble(); ex_cnt(32'd1, 32'd0);
      clr(); InstrF = 32'hC0DE_0010; tick();
      ex(S_PCF, "resume_PCF", 32'h14);
      ex_ifid(32'hC0DE_0010, 32'h10, 32'h14, 1'b1); ex_capture(32'hC, 32'h10, 1'b1);

      // Taken branch redirect with D and E flush
      clr(); PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1; FlushE = 1'b1;
      InstrF = 32'hC0DE_0014; tick();
      ex(S_PCF, "br_PCF", 32'h100); ex(S_PC4F, "br_PCPlus4F", 32'h104);
      ex_ifid(32'h0000_0013, 32'h0, 32'h0, 1'b0); ex_bubble(); ex_cnt(32'd1, 32'd1);

      // Flush beats a simultaneous stall on IF/ID
      clr(); FlushD = 1'b1; StallD = 1'b1; InstrF = 32'hC0DE_0100; tick();
      ex(S_PCF, "fs_PCF", 32'h104);
      ex_ifid(32'h0000_0013, 32'h0, 32'h0, 1'b0); ex_capture(32'h0, 32'h0, 1'b0);
      ex_cnt(32'd1, 32'd2);

      // Redirect wins over a fetch stall
      clr(); PCSrcE = 1'b1; PCTargetE = 32'h40; StallF = 1'b1; StallD = 1'b1;
      InstrF = 32'hC0DE_0104; tick();
      ex(S_PCF, "rdst_PCF", 32'h40);
      ex_ifid(32'h0000_0013, 32'h0, 32'h0, 1'b0); ex_cnt(32'd2, 32'd2);

      // PC wrap at the top of the address space
      clr(); PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; InstrF = 32'h5555_0033; tick();
      ex(S_PCF, "top_PCF", 32'hFFFF_FFFC); ex(S_PC4F, "top_PCPlus4F", 32'h0);
      ex_ifid(32'h5555_0033, 32'h40, 32'h44, 1'b1); ex_capture(32'h0, 32'h0, 1'b0);
      clr(); InstrF = 32'h6666_0013; tick();
      ex(S_PCF, "wrap_PCF", 32'h0); ex(S_PC4F, "wrap_PCPlus4F", 32'h4);
      ex_ifid(32'h6666_0013, 32'hFFFF_FFFC, 32'h0, 1'b1); ex_capture(32'h40, 32'h44, 1'b1);

      // Counter saturation: both counters start at 2 and stop at 15
      for (int k = 1; k <= 20; k++) begin
         clr(); StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; tick();
         ex(S_PCF, "sat_PCF", 32'h0);
         ex_cnt((k + 2 > 15) ? 32'd15 : 32'(k + 2), (k + 2 > 15) ? 32'd15 : 32'(k + 2));
      end

      // Mid-run reset overrides every control input
      clr(); PCSrcE = 1'b1; PCTargetE = 32'h80; tick();
      ex(S_PCF, "pre_PCF", 32'h80); ex_cnt(32'd15, 32'd15);
      clr(); reset = 1'b1; StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
      PCSrcE = 1'b1; PCTargetE = 32'h200; InstrF = 32'h7777_0013; tick();
      ex(S_PCF, "mrst_PCF", 32'h0);
      ex_ifid(32'h0000_0013, 32'h0, 32'h0, 1'b0); ex_bubble(); ex_cnt(32'd0, 32'd0);
      clr(); InstrF = 32'h8888_0013; tick();
      ex(S_PCF, "post_PCF", 32'h4);
      ex_ifid(32'h8888_0013, 32'h0, 32'h4, 1'b1); ex_cnt(32'd0, 32'd0);

      clr();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Consumer of the hazard controls StallF, StallD, FlushD and FlushE in the 5-stage RV32I pipeline. It also consumes the PC redirect PCSrcE/PCTargetE.
- Holds three things: the PC register, the IF/ID pipeline register and the ID/EX pipeline register. It applies stall, flush and advance to each one.
- Two event counters record stalled cycles and redirect flushes.
- Sits between the imem/decode logic and the execute stage.

Parameters:
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, PCF value after reset
- CNT_W, 16, width of the event counters (saturating)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- StallF  in  1  hold PC
- StallD  in  1  hold IF/ID
- FlushD  in  1  clear IF/ID
- FlushE  in  1  clear ID/EX
- PCSrcE  in  1  take redirect
- PCTargetE  in  XLEN  redirect target
- InstrF  in  32  instruction from imem
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode controls
- ResultSrcD  in  2  result select
- ALUControlD  in  3  ALU op
- RD1D, RD2D, ImmExtD  in  XLEN each  operands
- Rs1D, Rs2D, RdD  in  5 each  register indices
- PCF  out  XLEN  fetch PC
- PCPlus4F  out  XLEN  PCF+4
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  IF/ID contents
- ValidD  out  1  IF/ID holds a real instruction
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E, ValidE  out  matching widths  ID/EX contents
- StallCnt  out  CNT_W  cycles with StallF=1
- FlushCnt  out  CNT_W  cycles with FlushD=1

Behaviour:
- All registers update on the rising edge of clk.
- Each register applies its conditions in this priority order: reset, then flush, then stall, then advance.
- Reset values:
  - PCF = RESET_PC.
  - InstrD = 32'h0000_0013 (NOP).
  - PCD = PCPlus4D = 0, ValidD = 0.
  - Every ID/EX output = 0, including ValidE. RegWriteE, MemWriteE, JumpE and BranchE are therefore 0.
  - StallCnt = FlushCnt = 0.
- PC register:
  - If PCSrcE=1, PCF <= PCTargetE. This holds even when StallF=1: the redirect wins.
  - Else if StallF=1, PCF holds.
  - Else PCF <= PCF+4.
  - PCPlus4F = PCF+4 is combinational, mod 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- IF/ID register:
  - FlushD=1: InstrD <= 32'h0000_0013, PCD <= 0, PCPlus4D <= 0, ValidD <= 0. Flush wins over StallD.
  - Else StallD=1: all IF/ID outputs hold.
  - Else: InstrD <= InstrF, PCD <= PCF, PCPlus4D <= PCPlus4F, ValidD <= 1.
- ID/EX register:
  - FlushE=1: all outputs <= 0 (bubble). Rs1E, Rs2E and RdE become 0, so no forwarding is produced from a bubble.
  - Else: capture the D-stage inputs, PCD and PCPlus4D. ValidE <= ValidD.
  - There is no E-stage stall input. Under a load-use stall, FlushE inserts the bubble while IF/ID holds.
- Latency: an instruction fetched at edge n appears on InstrD after edge n+1 and in E after edge n+2, absent stall or flush.
- Counters:
  - StallCnt +1 on every edge with StallF=1; FlushCnt +1 on every edge with FlushD=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - Both clear only on reset.
- Reset mid-operation: all state returns to its reset values at the next edge regardless of any control input. On the first edge after reset deasserts, PCF advances to RESET_PC+4.
- Combinations that cannot occur in normal operation (e.g. StallD=1 with FlushD=1) resolve by the priority order above; no assertion or error is raised.

Test Plan:
- Reset then run 4 cycles with no stall or flush, InstrF = PC-indexed words -> PCF = 0, 4, 8, 12, 16; InstrD lags by one cycle; ValidE = 1 from cycle 3 on.
- Load-use stall: StallF = StallD = FlushE = 1 for 1 cycle with PCF=0x10 and InstrD=0xAAAA_0003 -> PCF stays 0x10, InstrD stays 0xAAAA_0003, all ID/EX outputs = 0, StallCnt = 1.
- Branch taken: PCSrcE=1, PCTargetE=0x100, FlushD = FlushE = 1 -> next PCF = 0x100, InstrD = 0x0000_0013, ValidD = 0, RegWriteE = 0, FlushCnt = 1.
- Redirect during stall: PCSrcE=1 and StallF=1 together, PCTargetE=0x40 -> PCF = 0x40.
- Wrap and saturation:
  - PCF = 0xFFFF_FFFC, no stall -> PCF = 0x0.
  - CNT_W=4, StallF held 20 cycles -> StallCnt = 15.
- Mid-run reset with StallF=1 and PCF=0x80 -> after the edge, PCF = RESET_PC and all counters and valid bits = 0.
